// File: rtl/aes_tx_serializer.sv
// rtl/aes_tx_serializer.sv - feeds an NBYTES cipher block, MSB byte first, into a byte-wide UART transmitter.
// Define AES_TX_CHKSUM_EN to append an XOR checksum byte after the block.
module aes_tx_serializer #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  input  logic [8*NBYTES-1:0]   blk_data,
  output logic                  blk_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  blk_sent,
  output logic                  active
);

  localparam int IW = $clog2(NBYTES + 1);
`ifdef AES_TX_CHKSUM_EN
  localparam int LAST = NBYTES;
`else
  localparam int LAST = NBYTES - 1;
`endif

  typedef enum logic [1:0] {IDLE, ARM, SEND, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [8*NBYTES-1:0]   blk_q, blk_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  blk_sent_q, blk_sent_d;
  logic                  out_en_q, out_en_d;
  logic [7:0]            cur_byte;

`ifdef AES_TX_CHKSUM_EN
  logic [7:0] chksum;

  always_comb begin
    chksum = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      chksum = chksum ^ blk_q[8*i +: 8];
    end
  end
`endif

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        cur_byte = blk_q[8*(NBYTES-i)-1 -: 8];
      end
    end
`ifdef AES_TX_CHKSUM_EN
    if (idx_q == IW'(NBYTES)) begin
      cur_byte = chksum;
    end
`endif
  end

  // out_en_q keeps blk_ready low through reset and for the first cycle after it.
  assign blk_ready = out_en_q && (state_q == IDLE) && !blk_sent_q;
  assign tx_start  = (state_q == SEND);
  assign tx_data   = tx_data_q;
  assign blk_sent  = blk_sent_q;
  assign active    = (state_q != IDLE) || blk_sent_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    blk_d      = blk_q;
    tx_data_d  = tx_data_q;
    blk_sent_d = 1'b0;
    out_en_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          blk_d   = blk_data;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!tx_busy) begin
          tx_data_d = cur_byte;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == IW'(LAST)) begin
            blk_sent_d = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      blk_q      <= '0;
      tx_data_q  <= 8'h00;
      blk_sent_q <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      blk_q      <= blk_d;
      tx_data_q  <= tx_data_d;
      blk_sent_q <= blk_sent_d;
      out_en_q   <= out_en_d;
    end
  end

endmodule

// File: tb/tb_aes_tx_serializer.sv
// tb/tb_aes_tx_serializer.sv - bench for aes_tx_serializer with a UART transmitter model and byte scoreboard.
module tb_aes_tx_serializer;

  localparam int NB    = 16;
  localparam int FRAME = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            blk_valid = 1'b0;
  logic [8*NB-1:0] blk_data = '0;
  logic            blk_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic            blk_sent;
  logic            active;

  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       stuck_busy = 1'b0;
  logic       inj_done = 1'b0;
  int         m_cnt = 0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         lat_cnt = 0;
  int         sent_cnt = 0;
  logic       prev_start = 1'b0;
  logic       prev_sent = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_byte = 8'h00;

  assign tx_busy = m_busy | stuck_busy;
  assign tx_done = m_done | inj_done;

  aes_tx_serializer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .blk_sent  (blk_sent),
    .active    (active)
  );

  always #5 clk = ~clk;

  // One clock: sample DUT 1ns after the edge, run protocol monitor, then the UART model.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt = 0;
      prev_sent = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (blk_sent) begin
        sent_cnt++;
        checks++;
        if (prev_sent || blk_ready) begin
          errors++;
          $display("FAIL sent_pulse: prev_sent=%0b blk_ready=%0b, required 0 0", prev_sent, blk_ready);
        end
      end
      if (prev_sent) begin
        checks++;
        if (blk_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_sent: got %0b required 1", blk_ready);
        end
      end
      if (tx_start && prev_start) begin
        checks++;
        if (tx_data !== prev_data) begin
          errors++;
          $display("FAIL tx_data_stable: got %02h required %02h", tx_data, prev_data);
        end
      end
      prev_sent = blk_sent;
      prev_start = tx_start;
      prev_data = tx_data;
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (tx_start) begin
        lat_cnt++;
        last_byte = tx_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL serial_byte %0d: got %02h, no byte expected", lat_cnt, tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL serial_byte %0d: got %02h required %02h", lat_cnt, tx_data, e);
          end
        end
        m_busy = 1'b1;
        m_cnt = FRAME;
      end
    end
  endtask

  task automatic push_block(input logic [8*NB-1:0] b);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(b[8*(NB-k)-1 -: 8]);
      x = x ^ b[8*(NB-k)-1 -: 8];
    end
`ifdef AES_TX_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (blk_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: blk_ready=%b required 1", name, blk_ready);
    end
  endtask

  task automatic wait_sent(input string name);
    int n;
    int start;
    n = 0;
    start = sent_cnt;
    while (sent_cnt == start && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (sent_cnt == start) begin
      errors++;
      $display("FAIL %s_sent_timeout: blk_sent count %0d required %0d", name, sent_cnt, start + 1);
    end
  endtask

  task automatic send_block(input string name, input logic [8*NB-1:0] b);
    wait_ready(name);
    blk_valid = 1'b1;
    blk_data = b;
    push_block(b);
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({blk_ready, tx_start, tx_data, blk_sent, active} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b start=%b data=%h sent=%b active=%b required all 0",
                 blk_ready, tx_start, tx_data, blk_sent, active);
      end
    end
    rst = 1'b0;
    checks++;
    if (blk_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 0", blk_ready);
    end
    tick();
    checks++;
    if (blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 1", blk_ready);
    end
  endtask

  task automatic test_basic();
    int base;
    base = sent_cnt;
    send_block("basic", 128'h00112233445566778899AABBCCDDEEFF);
    wait_sent("basic");
    repeat (3) tick();
    checks++;
    if (active !== 1'b0 || sent_cnt != base + 1) begin
      errors++;
      $display("FAIL basic_end: active=%b sent=%0d required 0 %0d", active, sent_cnt - base, 1);
    end
    check_drained("basic");
  endtask

  task automatic test_busy_stuck();
    int starts;
    starts = 0;
    stuck_busy = 1'b1;
    send_block("stuck", 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3);
    for (int i = 0; i < 50; i++) begin
      inj_done = (i == 20);
      tick();
      if (tx_start !== 1'b0) starts++;
    end
    inj_done = 1'b0;
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL stuck_start: tx_start seen %0d cycles required 0", starts);
    end
    stuck_busy = 1'b0;
    wait_sent("stuck");
    tick();
    check_drained("stuck");
  endtask

  task automatic test_back_to_back();
    int base;
    logic [8*NB-1:0] a;
    logic [8*NB-1:0] b;
    a = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    b = 128'h55AA55AA_12345678_9ABCDEF0_00FF00FF;
    wait_ready("b2b_a");
    base = sent_cnt;
    blk_valid = 1'b1;
    blk_data = a;
    push_block(a);
    tick();
    blk_data = b;
    wait_ready("b2b_b");
    checks++;
    if (sent_cnt != base + 1) begin
      errors++;
      $display("FAIL b2b_order: blk_sent count %0d before B capture required %0d", sent_cnt - base, 1);
    end
    push_block(b);
    tick();
    blk_valid = 1'b0;
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture: active=%b required 1", active);
    end
    wait_sent("b2b");
    tick();
    checks++;
    if (sent_cnt != base + 2) begin
      errors++;
      $display("FAIL b2b_count: blk_sent count %0d required 2", sent_cnt - base);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid();
    int base;
    int start;
    int n;
    base = sent_cnt;
    start = lat_cnt;
    send_block("mid", 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF);
    n = 0;
    while (lat_cnt < start + 6 && n < 1000) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tx_start !== 1'b0 || blk_sent !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: start=%b sent=%b active=%b required 0 0 0", tx_start, blk_sent, active);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (sent_cnt != base || lat_cnt != start + 6) begin
      errors++;
      $display("FAIL mid_abandon: sent=%0d bytes=%0d required 0 6", sent_cnt - base, lat_cnt - start);
    end
    send_block("fresh", 128'h1020304050607080_90A0B0C0D0E0F001);
    wait_sent("fresh");
    tick();
    check_drained("fresh");
  endtask

`ifdef AES_TX_CHKSUM_EN
  task automatic test_chksum();
    send_block("chk_ones", {NB{8'h01}});
    wait_sent("chk_ones");
    checks++;
    if (last_byte !== 8'h00) begin
      errors++;
      $display("FAIL chk_ones: got %02h required 00", last_byte);
    end
    send_block("chk_one", {8'h01, {(NB-1){8'h00}}});
    wait_sent("chk_one");
    checks++;
    if (last_byte !== 8'h01) begin
      errors++;
      $display("FAIL chk_one: got %02h required 01", last_byte);
    end
    tick();
    check_drained("chk");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_busy_stuck();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_TX_CHKSUM_EN
    test_chksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
